// File: rtl/scalar_multiply_unit.sv
// Scales an m x n matrix (packed in a fixed 5x5 grid of 8-bit elements) by a 4-bit scalar.
// Define SCALAR_MUL_REG_OUT_EN to register scalarMul/valid on clk; otherwise purely combinational.
module scalar_multiply_unit (
    input  logic         clk,
    input  logic         reset,
    input  logic [2:0]   m,
    input  logic [2:0]   n,
    input  logic [3:0]   scalarValue,
    input  logic [199:0] matrixA,
    output logic [199:0] scalarMul,
    output logic         valid
);

    logic [4:0]   row_en_s;
    logic [4:0]   col_en_s;
    logic         dims_ok_s;
    logic [7:0]   scalar_ext_s;
    logic [199:0] comb_mul_s;

    // Thermometer row mask; an illegal row count yields an all-zero mask.
    always_comb begin
        row_en_s = 5'b00000;
        case (m)
            3'd1:    row_en_s = 5'b00001;
            3'd2:    row_en_s = 5'b00011;
            3'd3:    row_en_s = 5'b00111;
            3'd4:    row_en_s = 5'b01111;
            3'd5:    row_en_s = 5'b11111;
            default: row_en_s = 5'b00000;
        endcase
    end

    // Thermometer column mask; an illegal column count yields an all-zero mask.
    always_comb begin
        col_en_s = 5'b00000;
        case (n)
            3'd1:    col_en_s = 5'b00001;
            3'd2:    col_en_s = 5'b00011;
            3'd3:    col_en_s = 5'b00111;
            3'd4:    col_en_s = 5'b01111;
            3'd5:    col_en_s = 5'b11111;
            default: col_en_s = 5'b00000;
        endcase
    end

    assign dims_ok_s    = (|row_en_s) & (|col_en_s);
    assign scalar_ext_s = {4'd0, scalarValue};

    // 25 independent 8x8 multiplies; an 8-bit result context gives the mod-256 wrap directly.
    always_comb begin
        comb_mul_s = 200'd0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                if (row_en_s[r] && col_en_s[c]) begin
                    comb_mul_s[(r*5+c)*8 +: 8] = matrixA[(r*5+c)*8 +: 8] * scalar_ext_s;
                end else begin
                    comb_mul_s[(r*5+c)*8 +: 8] = 8'd0;
                end
            end
        end
    end

`ifdef SCALAR_MUL_REG_OUT_EN
    logic [199:0] mul_r;
    logic         valid_r;

    // Output register: one-cycle latency, asynchronously cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_r   <= 200'd0;
            valid_r <= 1'b0;
        end else begin
            mul_r   <= comb_mul_s;
            valid_r <= dims_ok_s;
        end
    end

    assign scalarMul = mul_r;
    assign valid     = valid_r;
`else
    logic unused_clk_s;

    assign unused_clk_s = clk;
    assign scalarMul    = reset ? 200'd0 : comb_mul_s;
    assign valid        = (~reset) & dims_ok_s;
`endif

endmodule

// File: tb/tb_scalar_multiply_unit.sv
// Directed self-checking bench for scalar_multiply_unit (works with or without SCALAR_MUL_REG_OUT_EN).
module tb_scalar_multiply_unit;

    logic         clk;
    logic         reset;
    logic [2:0]   m;
    logic [2:0]   n;
    logic [3:0]   scalarValue;
    logic [199:0] matrixA;
    logic [199:0] scalarMul;
    logic         valid;

    int checks;
    int errors;

    scalar_multiply_unit dut (
        .clk         (clk),
        .reset       (reset),
        .m           (m),
        .n           (n),
        .scalarValue (scalarValue),
        .matrixA     (matrixA),
        .scalarMul   (scalarMul),
        .valid       (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [199:0] put(input logic [199:0] v, input int r, input int c,
                                         input logic [7:0] x);
        v[(r*5+c)*8 +: 8] = x;
        return v;
    endfunction

    // Let the inputs take effect: one edge when registered, a short delay otherwise.
    task automatic settle;
`ifdef SCALAR_MUL_REG_OUT_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
    endtask

    task automatic test_reset;
        logic [199:0] exp_v;
        reset = 1'b1;
        m = 3'd2; n = 3'd3; scalarValue = 4'd3;
        matrixA = '0;
        matrixA = put(matrixA, 0, 0, 8'd1);
        matrixA = put(matrixA, 1, 2, 8'd5);
        exp_v = '0;
        exp_v = put(exp_v, 0, 0, 8'd3);
        exp_v = put(exp_v, 1, 2, 8'd15);
        #3;
        checks++;
        if (scalarMul !== 200'd0) begin errors++; $display("FAIL reset_init_mul got=%h exp=0", scalarMul); end
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL reset_init_valid got=%b exp=0", valid); end
        reset = 1'b0;
        settle();
        checks++;
        if (scalarMul !== exp_v) begin errors++; $display("FAIL reset_release_mul got=%h exp=%h", scalarMul, exp_v); end
        checks++;
        if (valid !== 1'b1) begin errors++; $display("FAIL reset_release_valid got=%b exp=1", valid); end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (scalarMul !== 200'd0) begin errors++; $display("FAIL reset_async_mul got=%h exp=0", scalarMul); end
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL reset_async_valid got=%b exp=0", valid); end
        reset = 1'b0;
`ifdef SCALAR_MUL_REG_OUT_EN
        #1;
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL reset_hold_until_edge got=%b exp=0", valid); end
`endif
        settle();
        checks++;
        if (scalarMul !== exp_v) begin errors++; $display("FAIL reset_reappear_mul got=%h exp=%h", scalarMul, exp_v); end
    endtask

    task automatic test_basic;
        logic [199:0] exp_v;
        m = 3'd2; n = 3'd3; scalarValue = 4'd3;
        matrixA = '0;
        matrixA = put(matrixA, 0, 0, 8'd1); matrixA = put(matrixA, 0, 1, 8'd2); matrixA = put(matrixA, 0, 2, 8'd3);
        matrixA = put(matrixA, 1, 0, 8'd3); matrixA = put(matrixA, 1, 1, 8'd4); matrixA = put(matrixA, 1, 2, 8'd5);
        exp_v = '0;
        exp_v = put(exp_v, 0, 0, 8'd3); exp_v = put(exp_v, 0, 1, 8'd6);  exp_v = put(exp_v, 0, 2, 8'd9);
        exp_v = put(exp_v, 1, 0, 8'd9); exp_v = put(exp_v, 1, 1, 8'd12); exp_v = put(exp_v, 1, 2, 8'd15);
        settle();
        checks++;
        if (scalarMul !== exp_v) begin errors++; $display("FAIL basic_mul got=%h exp=%h", scalarMul, exp_v); end
        checks++;
        if (valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", valid); end
    endtask

    task automatic test_overflow;
        m = 3'd1; n = 3'd1; scalarValue = 4'd3;
        matrixA = '0;
        matrixA = put(matrixA, 0, 0, 8'd100);
        settle();
        checks++;
        if (scalarMul !== {192'd0, 8'd44}) begin errors++; $display("FAIL overflow_100x3 got=%h exp=2c", scalarMul); end
        checks++;
        if (valid !== 1'b1) begin errors++; $display("FAIL overflow_valid got=%b exp=1", valid); end
        matrixA = put(matrixA, 0, 0, 8'd255);
        scalarValue = 4'd15;
        settle();
        checks++;
        if (scalarMul !== {192'd0, 8'd241}) begin errors++; $display("FAIL overflow_255x15 got=%h exp=f1", scalarMul); end
        scalarValue = 4'd0;
        settle();
        checks++;
        if (scalarMul !== 200'd0 || valid !== 1'b1) begin
            errors++; $display("FAIL zero_scalar got=%h/%b exp=0/1", scalarMul, valid);
        end
    endtask

    task automatic test_masking;
        logic [199:0] exp_v;
        m = 3'd2; n = 3'd2; scalarValue = 4'd2;
        matrixA = {25{8'd1}};
        matrixA = put(matrixA, 2, 0, 8'd7);
        matrixA = put(matrixA, 0, 3, 8'd9);
        exp_v = '0;
        exp_v = put(exp_v, 0, 0, 8'd2); exp_v = put(exp_v, 0, 1, 8'd2);
        exp_v = put(exp_v, 1, 0, 8'd2); exp_v = put(exp_v, 1, 1, 8'd2);
        settle();
        checks++;
        if (scalarMul !== exp_v) begin errors++; $display("FAIL masking_mul got=%h exp=%h", scalarMul, exp_v); end
        checks++;
        if (valid !== 1'b1) begin errors++; $display("FAIL masking_valid got=%b exp=1", valid); end
    endtask

    task automatic test_illegal_dims;
        logic [2:0] ms [3];
        logic [2:0] ns [3];
        ms[0] = 3'd0; ns[0] = 3'd3;
        ms[1] = 3'd6; ns[1] = 3'd2;
        ms[2] = 3'd3; ns[2] = 3'd7;
        matrixA = {25{8'd5}};
        scalarValue = 4'd7;
        for (int i = 0; i < 3; i++) begin
            m = ms[i]; n = ns[i];
            settle();
            checks++;
            if (scalarMul !== 200'd0) begin errors++; $display("FAIL illegal_mul[%0d] got=%h exp=0", i, scalarMul); end
            checks++;
            if (valid !== 1'b0) begin errors++; $display("FAIL illegal_valid[%0d] got=%b exp=0", i, valid); end
        end
    endtask

    task automatic test_full;
        m = 3'd5; n = 3'd5; scalarValue = 4'd15;
        matrixA = {25{8'd1}};
        settle();
        checks++;
        if (scalarMul !== {25{8'd15}}) begin errors++; $display("FAIL full_mul got=%h exp=all 0f", scalarMul); end
        checks++;
        if (valid !== 1'b1) begin errors++; $display("FAIL full_valid got=%b exp=1", valid); end
    endtask

`ifdef SCALAR_MUL_REG_OUT_EN
    task automatic test_reg_latency;
        m = 3'd1; n = 3'd1; scalarValue = 4'd3;
        matrixA = '0;
        matrixA = put(matrixA, 0, 0, 8'd10);
        settle();
        scalarValue = 4'd4;
        #2;
        checks++;
        if (scalarMul !== {192'd0, 8'd30}) begin errors++; $display("FAIL reg_hold got=%h exp=1e", scalarMul); end
        settle();
        checks++;
        if (scalarMul !== {192'd0, 8'd40}) begin errors++; $display("FAIL reg_update got=%h exp=28", scalarMul); end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_overflow();
        test_masking();
        test_illegal_dims();
        test_full();
`ifdef SCALAR_MUL_REG_OUT_EN
        test_reg_latency();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
